// File: rtl/decode_pkg.sv
// Shared widths, RV32I opcode constants, operation classes and exception codes
// for the minuteCore decode stage.
package decode_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;
    localparam int EX_WIDTH   = 3;
    localparam int OP_WIDTH   = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [OP_WIDTH:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_ALUI   = 4'd7,
        OP_ALU    = 4'd8,
        OP_SYSTEM = 4'd9
    } op_e;

    localparam logic [EX_WIDTH:0] EX_NONE                = 4'd0;
    localparam logic [EX_WIDTH:0] EX_INSTR_ADDR_MISALIGN = 4'd1;
    localparam logic [EX_WIDTH:0] EX_ILLEGAL_INSTR       = 4'd2;
    localparam logic [EX_WIDTH:0] EX_BREAKPOINT          = 4'd3;
    localparam logic [EX_WIDTH:0] EX_ECALL               = 4'd4;

    // Combinational decode result for the instruction currently offered by fetch.
    typedef struct packed {
        op_e                op;
        logic               use_rs1;
        logic               use_rs2;
        logic               rd_write;
        logic [31:0]        imm;
        logic [EX_WIDTH:0]  exc;
    } dec_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_SIZE:0] pc;
        op_e                op;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic [31:0]        rs1_val;
        logic [31:0]        rs2_val;
        logic [31:0]        imm;
        logic [4:0]         rd;
        logic               rd_write;
        logic [EX_WIDTH:0]  exc;
    } out_t;

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// x0 hard-wired to zero, and a same-cycle write-to-read bypass.
module decode_regfile (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    output logic [31:0] rd_data_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_b
);

    // NOTE: the storage array has no reset; its contents are architecturally undefined until written.
    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != 5'd0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 5'd0)                   ? 32'd0   :
                       (wr_en && (wr_addr == rd_addr_a))     ? wr_data :
                                                               mem_q[rd_addr_a];

    assign rd_data_b = (rd_addr_b == 5'd0)                   ? 32'd0   :
                       (wr_en && (wr_addr == rd_addr_b))     ? wr_data :
                                                               mem_q[rd_addr_b];

endmodule

// File: rtl/decode.sv
// minuteCore decode stage: instruction decode, immediate generation, operand read,
// destination scoreboard with hazard stall, and the registered hand-off to execute.
module decode
    import decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_SIZE:0]  instr,
    input  logic [ADDR_SIZE:0]   PC,
    input  logic [EX_WIDTH:0]    exception,
    input  logic                 pipeline_valid,
    output logic                 stall,
    input  logic                 flush,
    input  logic                 ex_stall,
    input  logic                 wb_enable,
    input  logic [4:0]           wb_rd,
    input  logic [31:0]          wb_data,
    output logic                 ex_valid,
    output logic [ADDR_SIZE:0]   ex_PC,
    output logic [OP_WIDTH:0]    ex_op,
    output logic [2:0]           ex_funct3,
    output logic                 ex_funct7b5,
    output logic [31:0]          ex_rs1_val,
    output logic [31:0]          ex_rs2_val,
    output logic [31:0]          ex_imm,
    output logic [4:0]           ex_rd,
    output logic                 ex_rd_write,
    output logic [EX_WIDTH:0]    ex_exception
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    decode_regfile u_regfile (
        .clk       (clk),
        .wr_en     (wb_enable),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_val),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_val)
    );

    dec_t dec;
    logic legal, writes_rd;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        dec       = '0;
        dec.op    = OP_SYSTEM;
        legal     = 1'b1;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec.op = OP_LUI;    writes_rd = 1'b1; dec.imm = imm_u; end
            OPC_AUIPC:  begin dec.op = OP_AUIPC;  writes_rd = 1'b1; dec.imm = imm_u; end
            OPC_JAL:    begin dec.op = OP_JAL;    writes_rd = 1'b1; dec.imm = imm_j; end
            OPC_JALR:   begin dec.op = OP_JALR;   writes_rd = 1'b1; dec.imm = imm_i; dec.use_rs1 = 1'b1; end
            OPC_BRANCH: begin dec.op = OP_BRANCH; dec.imm = imm_b; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
            OPC_LOAD:   begin dec.op = OP_LOAD;   writes_rd = 1'b1; dec.imm = imm_i; dec.use_rs1 = 1'b1; end
            OPC_STORE:  begin dec.op = OP_STORE;  dec.imm = imm_s; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
            OPC_OP_IMM: begin dec.op = OP_ALUI;   writes_rd = 1'b1; dec.imm = imm_i; dec.use_rs1 = 1'b1; end
            OPC_OP:     begin dec.op = OP_ALU;    writes_rd = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
            OPC_SYSTEM: begin dec.op = OP_SYSTEM; dec.imm = imm_i; end
            default:    legal = 1'b0;
        endcase

        // A fetch fault outranks anything found in the (possibly garbage) instruction word.
        if (exception != EX_NONE) begin
            dec.exc = exception;
        end else if (!legal) begin
            dec.exc = EX_ILLEGAL_INSTR;
        end else if ((opcode == OPC_SYSTEM) && (instr[14:12] == 3'd0) && (instr[31:20] == 12'h000)) begin
            dec.exc = EX_ECALL;
        end else if ((opcode == OPC_SYSTEM) && (instr[14:12] == 3'd0) && (instr[31:20] == 12'h001)) begin
            dec.exc = EX_BREAKPOINT;
        end else begin
            dec.exc = EX_NONE;
        end
        dec.rd_write = writes_rd && (rd != 5'd0) && (dec.exc == EX_NONE);
    end

    logic [31:0] busy_q, busy_d;
    logic [31:0] wb_clear, busy_eff;
    logic        hz, accept;

    always_comb begin
        wb_clear = '0;
        if (wb_enable) begin
            wb_clear[wb_rd] = 1'b1;
        end
    end

    // A same-cycle writeback already releases its register for the hazard check.
    assign busy_eff = busy_q & ~wb_clear;

    assign hz = pipeline_valid && ((dec.use_rs1 && busy_eff[rs1]) ||
                                   (dec.use_rs2 && busy_eff[rs2]) ||
                                   (dec.rd_write && busy_eff[rd]));

    assign stall  = pipeline_valid && (hz || ex_stall) && !flush;
    assign accept = pipeline_valid && !stall && !flush;

    out_t out_q, out_d;

    always_comb begin
        busy_d = busy_eff;
        if (flush && out_q.valid && out_q.rd_write) begin
            busy_d[out_q.rd] = 1'b0;
        end
        if (accept && dec.rd_write) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        out_d = out_q;
        if (accept) begin
            out_d.valid    = 1'b1;
            out_d.pc       = PC;
            out_d.op       = dec.op;
            out_d.funct3   = instr[14:12];
            out_d.funct7b5 = instr[30];
            out_d.rs1_val  = rs1_val;
            out_d.rs2_val  = rs2_val;
            out_d.imm      = dec.imm;
            out_d.rd       = rd;
            out_d.rd_write = dec.rd_write;
            out_d.exc      = dec.exc;
        end else if (!(ex_stall && !flush)) begin
            out_d.valid = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    assign ex_valid     = out_q.valid;
    assign ex_PC        = out_q.pc;
    assign ex_op        = out_q.op;
    assign ex_funct3    = out_q.funct3;
    assign ex_funct7b5  = out_q.funct7b5;
    assign ex_rs1_val   = out_q.rs1_val;
    assign ex_rs2_val   = out_q.rs2_val;
    assign ex_imm       = out_q.imm;
    assign ex_rd        = out_q.rd;
    assign ex_rd_write  = out_q.rd_write;
    assign ex_exception = out_q.exc;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a driver predicts stall and the decoded result from an
// instruction-level model; a monitor pops expectations whenever execute sees a new instruction.
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, PC;
    logic [3:0]  exception;
    logic        pipeline_valid, stall, flush, ex_stall;
    logic        wb_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_PC;
    logic [3:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_write;
    logic [3:0]  ex_exception;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .reset(reset), .instr(instr), .PC(PC), .exception(exception),
        .pipeline_valid(pipeline_valid), .stall(stall), .flush(flush), .ex_stall(ex_stall),
        .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_op(ex_op), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_write(ex_rd_write), .ex_exception(ex_exception)
    );

    typedef struct {
        logic [31:0] pc;
        op_e         op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        rdw;
        logic [3:0]  exc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid, m_rdw;
    logic [4:0]  m_rd;
    logic [31:0] pc_ctr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        int s;
        s = int'(v) <<< (32 - bits);
        return 32'(s >>> (32 - bits));
    endfunction

    // Instruction-set level view: operation class, operand usage, immediate value, trap cause.
    function automatic void ref_decode(input logic [31:0] i, input logic [3:0] exc_in,
                                       output exp_t e, output bit u1, output bit u2);
        bit known, wr;
        known = 1; wr = 0; u1 = 0; u2 = 0;
        e.pc = '0; e.a = '0; e.b = '0; e.imm = '0; e.op = OP_SYSTEM;
        e.f3 = i[14:12]; e.f7 = i[30]; e.rd = i[11:7];
        case (i[6:0])
            7'h37: begin e.op = OP_LUI;    wr = 1; e.imm = i & 32'hFFFFF000; end
            7'h17: begin e.op = OP_AUIPC;  wr = 1; e.imm = i & 32'hFFFFF000; end
            7'h6F: begin e.op = OP_JAL;    wr = 1; e.imm = sx({i[31], i[19:12], i[20], i[30:21]}, 20) * 2; end
            7'h67: begin e.op = OP_JALR;   wr = 1; u1 = 1; e.imm = sx(i[31:20], 12); end
            7'h63: begin e.op = OP_BRANCH; u1 = 1; u2 = 1; e.imm = sx({i[31], i[7], i[30:25], i[11:8]}, 12) * 2; end
            7'h03: begin e.op = OP_LOAD;   wr = 1; u1 = 1; e.imm = sx(i[31:20], 12); end
            7'h23: begin e.op = OP_STORE;  u1 = 1; u2 = 1; e.imm = sx({i[31:25], i[11:7]}, 12); end
            7'h13: begin e.op = OP_ALUI;   wr = 1; u1 = 1; e.imm = sx(i[31:20], 12); end
            7'h33: begin e.op = OP_ALU;    wr = 1; u1 = 1; u2 = 1; end
            7'h73: begin e.op = OP_SYSTEM; e.imm = sx(i[31:20], 12); end
            default: known = 0;
        endcase
        if (exc_in != EX_NONE)                                          e.exc = exc_in;
        else if (!known)                                                e.exc = EX_ILLEGAL_INSTR;
        else if (i[6:0] == 7'h73 && i[14:12] == 0 && i[31:20] == 12'd0) e.exc = EX_ECALL;
        else if (i[6:0] == 7'h73 && i[14:12] == 0 && i[31:20] == 12'd1) e.exc = EX_BREAKPOINT;
        else                                                            e.exc = EX_NONE;
        e.rdw = wr && (e.rd != 0) && (e.exc == EX_NONE);
    endfunction

    // One clock of stimulus: drive, check stall, then advance the model to the next edge.
    task automatic cycle(input bit rst, input bit pv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [3:0] ex, input bit fl, input bit exs, input bit wbe,
                         input logic [4:0] wrd, input logic [31:0] wd, output bit stalled);
        exp_t e;
        bit   u1, u2, hz, st, acc;
        bit   beff [32];
        logic [4:0] s1, s2;
        @(posedge clk);
        #1;
        reset = rst; pipeline_valid = pv; instr = ins; PC = pc; exception = ex;
        flush = fl; ex_stall = exs; wb_enable = wbe; wb_rd = wrd; wb_data = wd;
        #1;
        ref_decode(ins, ex, e, u1, u2);
        s1 = ins[19:15];
        s2 = ins[24:20];
        e.pc = pc;
        e.a  = (s1 == 0) ? 32'd0 : (wbe && wrd == s1) ? wd : m_regs[s1];
        e.b  = (s2 == 0) ? 32'd0 : (wbe && wrd == s2) ? wd : m_regs[s2];
        beff = m_busy;
        if (wbe) beff[wrd] = 0;
        hz = pv && ((u1 && beff[s1]) || (u2 && beff[s2]) || (e.rdw && beff[e.rd]));
        st = pv && (hz || exs) && !fl;
        if (!rst) check("stall", stall, st);
        stalled = st;
        acc = !rst && pv && !st && !fl;
        if (wbe && wrd != 0) m_regs[wrd] = wd;
        if (rst) begin
            foreach (m_busy[r]) m_busy[r] = 0;
            m_valid = 0;
        end else begin
            m_busy = beff;
            if (fl && m_valid && m_rdw) m_busy[m_rd] = 0;
            if (acc && e.rdw) m_busy[e.rd] = 1;
            if (acc) begin
                m_valid = 1; m_rd = e.rd; m_rdw = e.rdw;
                exp_q.push_back(e);
            end else if (!(exs && !fl)) begin
                m_valid = 0;
            end
        end
    endtask

    // Offer one instruction until accepted, retiring one busy register per stalled cycle.
    task automatic issue(input logic [31:0] ins, input logic [3:0] ex);
        bit st, done;
        int b;
        done = 0;
        pc_ctr += 4;
        for (int k = 0; k < 20 && !done; k++) begin
            b = 0;
            for (int r = 31; r >= 1; r--) if (m_busy[r]) b = r;
            cycle(0, 1, ins, pc_ctr, ex, 0, 0, b > 0, 5'(b), $urandom, st);
            done = !st;
        end
        check("issue_accepted", 32'(done), 32'd1);
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_pc"},    ex_PC,        e.pc);
        check({tag, "_op"},    ex_op,        e.op);
        check({tag, "_f3"},    ex_funct3,    e.f3);
        check({tag, "_f7b5"},  ex_funct7b5,  e.f7);
        check({tag, "_rs1"},   ex_rs1_val,   e.a);
        check({tag, "_rs2"},   ex_rs2_val,   e.b);
        check({tag, "_imm"},   ex_imm,       e.imm);
        check({tag, "_rd"},    ex_rd,        e.rd);
        check({tag, "_rdw"},   ex_rd_write,  e.rdw);
        check({tag, "_exc"},   ex_exception, e.exc);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] w;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 15) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
        return w;
    endfunction

    // Monitor: a new instruction appears unless the previous cycle held the register.
    initial begin
        bit   prev_hold, have;
        exp_t cur;
        prev_hold = 0;
        have      = 0;
        forever begin
            @(negedge clk);
            if (ex_valid === 1'b1) begin
                if (prev_hold && have) begin
                    compare_out("held", cur);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got ex_valid=1 expected no instruction at %0t", $time);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                    compare_out("new", cur);
                end
            end
            prev_hold = ex_stall && !flush && !reset;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end at %0t", $time);
        $fatal(1);
    end

    initial begin
        bit          st, last_st, pv, fl, exs, wbe;
        logic [4:0]  wrd;
        logic [31:0] wd, r_ins;
        logic [3:0]  r_ex;
        int          busy_list[$];

        reset = 1; pipeline_valid = 0; instr = '0; PC = '0; exception = EX_NONE;
        flush = 0; ex_stall = 0; wb_enable = 0; wb_rd = '0; wb_data = '0;
        foreach (m_regs[r]) m_regs[r] = '0;
        foreach (m_busy[r]) m_busy[r] = 0;
        m_valid = 0; m_rdw = 0; m_rd = '0;

        cycle(1, 0, 0, 0, EX_NONE, 0, 0, 0, 0, 0, st);
        cycle(1, 0, 0, 0, EX_NONE, 0, 0, 0, 0, 0, st);
        cycle(0, 0, 0, 0, EX_NONE, 0, 0, 0, 0, 0, st);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_exc",   ex_exception, EX_NONE);
        check("rst_ex_pc",    ex_PC, 0);
        check("rst_ex_imm",   ex_imm, 0);
        check("rst_ex_rd",    ex_rd, 0);
        check("rst_ex_rdw",   ex_rd_write, 0);
        check("rst_ex_rs1",   ex_rs1_val, 0);

        for (int r = 1; r < 32; r++) cycle(0, 0, 0, 0, EX_NONE, 0, 0, 1, 5'(r), $urandom, st);

        // addi x1,x0,5 then add x2,x1,x1 waiting on x1's writeback
        cycle(0, 1, 32'h00500093, 32'd0, EX_NONE, 0, 0, 0, 0, 0, st);
        cycle(0, 1, 32'h00108133, 32'd4, EX_NONE, 0, 0, 0, 0, 0, st);
        cycle(0, 1, 32'h00108133, 32'd4, EX_NONE, 0, 0, 1, 5'd1, 32'd5, st);
        // lui x3 held off by ex_stall for three cycles, then accepted and flushed
        for (int k = 0; k < 3; k++) cycle(0, 1, 32'h123451B7, 32'd8, EX_NONE, 0, 1, 0, 0, 0, st);
        cycle(0, 1, 32'h123451B7, 32'd8, EX_NONE, 0, 0, 0, 0, 0, st);
        cycle(0, 0, 32'h0, 32'd0, EX_NONE, 1, 0, 0, 0, 0, st);
        // addi x4,x3,1 must not stall once the flush released x3
        cycle(0, 1, 32'h00118213, 32'd12, EX_NONE, 0, 0, 0, 0, 0, st);
        pc_ctr = 32'd12;

        issue(32'h000001FF, EX_NONE);
        issue(32'h00500313, EX_INSTR_ADDR_MISALIGN);
        issue(32'hFE000EE3, EX_NONE);
        issue(32'h00112623, EX_NONE);
        issue(32'h0080006F, EX_NONE);
        issue(32'hFFDFF0EF, EX_NONE);
        issue(32'h00000073, EX_NONE);
        issue(32'h00100073, EX_NONE);

        // reset while fetch is being stalled
        cycle(0, 1, 32'h00700293, 32'd100, EX_NONE, 0, 1, 0, 0, 0, st);
        cycle(1, 1, 32'h00700293, 32'd100, EX_NONE, 0, 1, 0, 0, 0, st);
        cycle(0, 0, 32'h00700293, 32'd100, EX_NONE, 0, 0, 0, 0, 0, st);
        check("rst_mid_stall_ex_valid", ex_valid, 0);

        last_st = 0;
        r_ins   = '0;
        r_ex    = EX_NONE;
        for (int n = 0; n < 3000; n++) begin
            if (!last_st) begin
                pv     = $urandom_range(0, 9) < 7;
                r_ins  = rand_instr();
                r_ex   = ($urandom_range(0, 9) == 0) ? EX_INSTR_ADDR_MISALIGN : EX_NONE;
                pc_ctr += 4;
            end else begin
                pv = 1;
            end
            fl  = $urandom_range(0, 15) == 0;
            exs = $urandom_range(0, 4) == 0;
            busy_list.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
            wbe = 0;
            wrd = '0;
            wd  = $urandom;
            if (busy_list.size() > 0 && $urandom_range(0, 9) < 4) begin
                wbe = 1;
                wrd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                wbe = 1;
                wrd = 5'($urandom_range(0, 31));
            end
            cycle(0, pv, r_ins, pc_ctr, r_ex, fl, exs, wbe, wrd, wd, last_st);
        end

        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, EX_NONE, 0, 0, 0, 0, 0, st);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the minuteCore RV32I pipeline: it sits between fetch and execute. It takes the fetched instruction word, PC and fetch exception, and decodes it into an operation class, immediate and destination. It reads source operands from the integrated register file and tracks in-flight destinations with a per-register scoreboard, stalling fetch on hazards. It presents one registered decoded instruction per cycle to execute and accepts register writeback from the end of the pipe.

## Interface
- No parameters. Widths come from the shared `def_params.v` macros: address is `ADDR_SIZE`+1 bits (32), instruction is `INSTR_SIZE`+1 bits (32), exception is `EX_WIDTH`+1 bits.
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- instr  in  32  instruction from fetch
- PC  in  32  PC of `instr`
- exception  in  `EX_WIDTH`+1  fetch exception code
- pipeline_valid  in  1  `instr`/`PC`/`exception` are valid
- stall  out  1  to fetch; combinational; fetch holds its outputs while high
- flush  in  1  from execute; cancel the younger instruction held in the decode output register
- ex_stall  in  1  execute cannot accept a new instruction this cycle
- wb_enable  in  1  register write strobe
- wb_rd  in  5  write register index
- wb_data  in  32  write data
- ex_valid  out  1  decoded instruction valid
- ex_PC  out  32  PC
- ex_op  out  `OP_WIDTH`+1  operation class (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_ALUI`, `OP_ALU`, `OP_SYSTEM`)
- ex_funct3  out  3  instr[14:12]
- ex_funct7b5  out  1  instr[30]
- ex_rs1_val, ex_rs2_val  out  32  operand values
- ex_imm  out  32  sign-extended immediate (I/S/B/U/J, selected by opcode; 0 for R-type)
- ex_rd  out  5  destination index
- ex_rd_write  out  1  instruction writes `ex_rd` (and `ex_rd` != 0)
- ex_exception  out  `EX_WIDTH`+1  exception code carried forward

## Operation
- Regfile: 32x32, x0 reads 0 and ignores writes. Write-before-read: if `wb_enable` and `wb_rd` equals a source index in the same cycle, the read returns `wb_data`.
- Scoreboard: `busy[31:1]`. A bit is set when an instruction with `ex_rd_write`=1 is accepted into the output register. It is cleared on `wb_enable` for `wb_rd`. If a set and a clear hit the same index in the same cycle, the set wins.
- Hazard `hz` = `pipeline_valid` and (rs1 used and `busy[rs1]`, or rs2 used and `busy[rs2]`, or rd written and `busy[rd]` (WAW)), where the clear from a same-cycle writeback is already applied. Source usage is by opcode: U/J use no sources; I/JALR/LOAD use rs1; R/S/B use rs1 and rs2.
- `stall` = `pipeline_valid` and (`hz` or `ex_stall`) and not `flush`.
- Accept is `pipeline_valid` and not `stall` and not `flush`. On accept the output register loads the decoded fields and `ex_valid`=1.
- When there is no accept: if `ex_stall` is high and there is no flush, the output register holds. Otherwise `ex_valid`=0, which inserts a bubble.
- Exceptions:
  - An incoming `exception` != `EX_NONE` passes through, and `ex_rd_write` is forced to 0.
  - Otherwise, an unknown opcode sets `EX_ILLEGAL_INSTR` (and `ex_rd_write`=0).
  - ECALL/EBREAK produce `OP_SYSTEM` with `EX_ECALL` / `EX_BREAKPOINT`.
- Flush: `ex_valid`<=0. If the output register held a valid instruction with `ex_rd_write`, clear its `busy[ex_rd]`. The WAW stall guarantees it is the only producer. The incoming fetch instruction is dropped that cycle.

## Timing
- Latency is 1 cycle from accept to `ex_valid`.
- Reset values: `ex_valid`=0, all data outputs 0, `ex_exception`=`EX_NONE`, `busy`=0. Regfile contents are not reset (simulation initialises them to 0).
- Reset mid-stall: the next cycle has `stall`=0 and `ex_valid`=0.
- `flush` has priority over `ex_stall`, over hazard, and over accept.
- `stall` depends combinationally only on the inputs and `busy`. It does not depend on the output register, apart from `ex_stall`.

## Structure
- Add to `def_params.v` (guarded by `INCLUDE_PARAMS`): `OP_WIDTH`, the `OP_*` codes, RV32I opcode constants, `EX_ILLEGAL_INSTR`, `EX_ECALL`, `EX_BREAKPOINT`.
- Sub-module `regfile`: 2 combinational read ports, 1 synchronous write port, with the write-before-read bypass.
- Decode logic, immediate generation, scoreboard and output register live in `decode`.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) at PC 0 → next cycle `ex_valid`=1, `ex_op`=`OP_ALUI`, `ex_imm`=5, `ex_rd`=1, `ex_rd_write`=1; `busy[1]`=1.
- `add x2,x1,x1` presented next while `busy[1]` → `stall`=1 and `ex_valid`=0. Drive `wb_enable`/`wb_rd`=1/`wb_data`=5 → the same cycle `stall`=0 and the next cycle `ex_rs1_val`=`ex_rs2_val`=5.
- `ex_stall`=1 for 3 cycles with a valid input → outputs hold and `stall`=1 throughout; on release the queued instruction is accepted.
- `flush` while the output register holds `lui x3,…` with `busy[3]`=1 → the next cycle `ex_valid`=0 and `busy[3]`=0.
- Opcode 0x7F → `ex_exception`=`EX_ILLEGAL_INSTR`, `ex_rd_write`=0, `busy` unchanged. An input with `EX_INSTR_ADDR_MISALIGN` passes through unchanged.
- `beq` with imm -4 (0xFE000EE3) → `ex_imm`=0xFFFFFFFC; `sw` and `jal` immediates checked against the reference sign-extension.
